// File: rtl/exe_dmem_req_pkg.sv
// Shared types and constants for the EXE-stage data-memory request path.
// Load/store type encodings, FSM states, exception codes and SRAM size codes.
package exe_dmem_req_pkg;

    typedef enum logic [2:0] {
        LS_B  = 3'd0,
        LS_BU = 3'd1,
        LS_H  = 3'd2,
        LS_HU = 3'd3,
        LS_W  = 3'd4,
        LS_WL = 3'd5,
        LS_WR = 3'd6
    } ls_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } dmem_state_e;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    localparam logic [1:0] SIZE_1B = 2'd0;
    localparam logic [1:0] SIZE_2B = 2'd1;
    localparam logic [1:0] SIZE_4B = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/exe_store_align.sv
// Combinational size/address/strobe/data formatting for one load/store,
// plus the natural-alignment check used for AdEL/AdES.
module exe_store_align
    import exe_dmem_req_pkg::*;
(
    input  logic [2:0]  ls_type,
    input  logic [31:0] vaddr,
    input  logic [31:0] rt_value,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misalign
);

    logic [1:0] a;
    assign a = vaddr[1:0];

    always_comb begin
        size     = SIZE_4B;
        addr     = vaddr;
        wstrb    = '0;
        wdata    = '0;
        misalign = 1'b0;
        case (ls_type_e'(ls_type))
            LS_B, LS_BU: begin
                size  = SIZE_1B;
                wstrb = 4'b0001 << a;
                wdata = {4{rt_value[7:0]}};
            end
            LS_H, LS_HU: begin
                size     = SIZE_2B;
                wstrb    = a[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{rt_value[15:0]}};
                misalign = a[0];
            end
            LS_W: begin
                wstrb    = 4'b1111;
                wdata    = rt_value;
                misalign = |a;
            end
            // Unaligned-word pair: word address, partial lanes, never faults.
            LS_WL: begin
                addr  = {vaddr[31:2], 2'b00};
                wstrb = 4'b1111 >> (2'd3 - a);
                wdata = rt_value >> (5'd24 - {a, 3'b000});
            end
            LS_WR: begin
                addr  = {vaddr[31:2], 2'b00};
                wstrb = 4'b1111 << a;
                wdata = rt_value << {a, 3'b000};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/exe_dmem_req.sv
// EXE-stage data-memory request generator: issues one SRAM-like request per
// load/store, holds it until addr_ok, and reports alignment exceptions.
module exe_dmem_req
    import exe_dmem_req_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        es_valid,
    input  logic        ms_allowin,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [2:0]  ls_type,
    input  logic [31:0] vaddr,
    input  logic [31:0] rt_value,
    input  logic        es_ex_in,
    input  logic        kill,
    input  logic        flush,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    output logic        mem_ready_go,
    output logic        es_req_issued,
    output logic        ex_adel,
    output logic        ex_ades,
    output logic [31:0] ex_badvaddr
);

    dmem_state_e state, state_nxt;

    logic        mem_op, misalign, adel, ades, issue_ok, pass_through;
    logic [1:0]  al_size;
    logic [31:0] al_addr, al_wdata;
    logic [3:0]  al_wstrb;
    dmem_req_t   cur_req, held_req, out_req;

    exe_store_align u_align (
        .ls_type  (ls_type),
        .vaddr    (vaddr),
        .rt_value (rt_value),
        .size     (al_size),
        .addr     (al_addr),
        .wstrb    (al_wstrb),
        .wdata    (al_wdata),
        .misalign (misalign)
    );

    assign mem_op       = mem_re | mem_we;
    assign adel         = es_valid & mem_re & misalign;
    assign ades         = es_valid & mem_we & misalign;
    assign issue_ok     = es_valid & mem_op & ~es_ex_in & ~adel & ~ades & ~kill & ~flush;
    assign pass_through = es_valid & (~mem_op | es_ex_in | adel | ades | kill);

    always_comb begin
        cur_req.wr    = mem_we;
        cur_req.size  = al_size;
        cur_req.addr  = al_addr;
        cur_req.wstrb = mem_we ? al_wstrb : '0;
        cur_req.wdata = mem_we ? al_wdata : '0;
    end

    // A waiting request is latched so it stays stable even after a flush
    // lets the EXE pipeline register move on while we drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            held_req <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && issue_ok && !data_sram_addr_ok)
                held_req <= cur_req;
        end
    end

    always_comb begin
        state_nxt     = state;
        data_sram_req = 1'b0;
        out_req       = '0;
        mem_ready_go  = 1'b0;
        es_req_issued = 1'b0;
        case (state)
            ST_IDLE: begin
                data_sram_req = issue_ok;
                out_req       = issue_ok ? cur_req : '0;
                mem_ready_go  = pass_through | (issue_ok & data_sram_addr_ok);
                es_req_issued = issue_ok & data_sram_addr_ok;
                if (issue_ok)
                    state_nxt = data_sram_addr_ok ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                data_sram_req = 1'b1;
                out_req       = held_req;
                mem_ready_go  = pass_through;
                // Accepted in the flush cycle: reported as issued so MEM cancels it.
                es_req_issued = data_sram_addr_ok & flush;
                if (data_sram_addr_ok)
                    state_nxt = flush ? ST_IDLE : ST_DONE;
                else if (flush)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                data_sram_req = 1'b1;
                out_req       = held_req;
                if (data_sram_addr_ok)
                    state_nxt = ST_IDLE;
            end
            ST_DONE: begin
                mem_ready_go  = 1'b1;
                es_req_issued = 1'b1;
                if ((es_valid & ms_allowin) | flush)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign data_sram_wr    = out_req.wr;
    assign data_sram_size  = out_req.size;
    assign data_sram_addr  = out_req.addr;
    assign data_sram_wstrb = out_req.wstrb;
    assign data_sram_wdata = out_req.wdata;

    assign ex_adel     = adel;
    assign ex_ades     = ades;
    assign ex_badvaddr = (adel | ades) ? vaddr : '0;

endmodule

// File: tb/tb_exe_dmem_req.sv
// Scoreboard bench for exe_dmem_req: stimulus pushes expected requests,
// a negedge monitor compares every cycle the DUT drives data_sram_req.
module tb_exe_dmem_req;

    localparam bit [2:0] T_B = 3'd0, T_BU = 3'd1, T_H = 3'd2, T_HU = 3'd3;
    localparam bit [2:0] T_W = 3'd4, T_WL = 3'd5, T_WR = 3'd6;

    logic        clk = 1'b0;
    logic        reset, es_valid, ms_allowin, mem_re, mem_we;
    logic [2:0]  ls_type;
    logic [31:0] vaddr, rt_value;
    logic        es_ex_in, kill, flush, addr_ok;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [3:0]  data_sram_wstrb;
    logic        mem_ready_go, es_req_issued, ex_adel, ex_ades;
    logic [31:0] ex_badvaddr;

    exe_dmem_req dut (
        .clk               (clk),
        .reset             (reset),
        .es_valid          (es_valid),
        .ms_allowin        (ms_allowin),
        .mem_re            (mem_re),
        .mem_we            (mem_we),
        .ls_type           (ls_type),
        .vaddr             (vaddr),
        .rt_value          (rt_value),
        .es_ex_in          (es_ex_in),
        .kill              (kill),
        .flush             (flush),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (addr_ok),
        .mem_ready_go      (mem_ready_go),
        .es_req_issued     (es_req_issued),
        .ex_adel           (ex_adel),
        .ex_ades           (ex_ades),
        .ex_badvaddr       (ex_badvaddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        wr;
        bit [1:0]  size;
        bit [31:0] addr;
        bit [3:0]  wstrb;
        bit [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   accepted = 0, expected_accepts = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endfunction

    function automatic int unsigned nbytes(bit [2:0] t);
        if (t == T_B || t == T_BU) return 1;
        if (t == T_H || t == T_HU) return 2;
        return 4;
    endfunction

    function automatic bit faults(bit [2:0] t, bit [31:0] va);
        if (t == T_WL || t == T_WR) return 1'b0;
        return (va % nbytes(t)) != 0;
    endfunction

    // Byte-lane view of what memory should see.
    function automatic exp_t model(bit st, bit [2:0] t, bit [31:0] va, bit [31:0] rt);
        exp_t e;
        int unsigned a = va % 4;
        e.wr    = st;
        e.size  = (nbytes(t) == 1) ? 2'd0 : (nbytes(t) == 2) ? 2'd1 : 2'd2;
        e.addr  = (t == T_WL || t == T_WR) ? va - a : va;
        e.wstrb = '0;
        e.wdata = '0;
        if (st) begin
            for (int i = 0; i < 4; i++) begin
                case (t)
                    T_B: begin
                        e.wdata[8*i +: 8] = rt[7:0];
                        e.wstrb[i] = (i == a);
                    end
                    T_H: begin
                        e.wdata[8*i +: 8] = rt[8*(i%2) +: 8];
                        e.wstrb[i] = (i / 2 == a / 2);
                    end
                    T_WL: if (i <= a) begin
                        e.wdata[8*i +: 8] = rt[8*(i+3-a) +: 8];
                        e.wstrb[i] = 1'b1;
                    end
                    T_WR: if (i >= a) begin
                        e.wdata[8*i +: 8] = rt[8*(i-a) +: 8];
                        e.wstrb[i] = 1'b1;
                    end
                    default: begin
                        e.wdata[8*i +: 8] = rt[8*i +: 8];
                        e.wstrb[i] = 1'b1;
                    end
                endcase
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && data_sram_req) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got req=1, want req=0");
            end else begin
                check("req_addr", data_sram_addr, sb[0].addr);
                check("req_wdata", data_sram_wdata, sb[0].wdata);
                check("req_wr_size_wstrb", {data_sram_wr, data_sram_size, data_sram_wstrb},
                      {sb[0].wr, sb[0].size, sb[0].wstrb});
                if (addr_ok) begin
                    void'(sb.pop_front());
                    accepted++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        es_valid = 0; mem_re = 0; mem_we = 0; es_ex_in = 0; kill = 0; flush = 0;
        addr_ok = 0; ms_allowin = 1; ls_type = 3'($urandom); vaddr = $urandom; rt_value = $urandom;
    endtask

    task automatic bubble();
        step();
        clear_inputs();
        @(negedge clk);
        check("idle_ctl", {data_sram_req, mem_ready_go, es_req_issued, ex_adel, ex_ades, data_sram_wr,
                           data_sram_size, data_sram_wstrb}, '0);
        check("idle_addr", data_sram_addr, '0);
        check("idle_wdata", data_sram_wdata, '0);
        check("idle_badvaddr", ex_badvaddr, '0);
    endtask

    task automatic run_mem(input bit st, input bit [2:0] t, input bit [31:0] va, input bit [31:0] rt,
                           input int unsigned delay, input int unsigned stall);
        step();
        clear_inputs();
        es_valid = 1; mem_re = !st; mem_we = st; ls_type = t; vaddr = va; rt_value = rt;
        if (faults(t, va)) begin
            addr_ok = 1'($urandom);
            @(negedge clk);
            check("fault_req", data_sram_req, 0);
            check("fault_adel_ades", {ex_adel, ex_ades}, {!st, st});
            check("fault_badvaddr", ex_badvaddr, va);
            check("fault_rdy_iss", {mem_ready_go, es_req_issued}, 2'b10);
            return;
        end
        sb.push_back(model(st, t, va, rt));
        expected_accepts++;
        for (int k = 0; k <= int'(delay); k++) begin
            if (k > 0) step();
            addr_ok = (k == int'(delay));
            @(negedge clk);
            check("hs_req", data_sram_req, 1);
            check("hs_rdy_iss", {mem_ready_go, es_req_issued}, {2{delay == 0}});
            check("hs_no_ex", {ex_adel, ex_ades}, 0);
        end
        for (int s = 0; s <= int'(stall); s++) begin
            step();
            addr_ok = 0;
            ms_allowin = (s == int'(stall));
            @(negedge clk);
            check("done_req", data_sram_req, 0);
            check("done_rdy_iss", {mem_ready_go, es_req_issued}, 2'b11);
        end
    endtask

    // kind 0: no memory op, 1: earlier exception attached, 2: kill on a store
    task automatic run_pass(input int unsigned kind);
        step();
        clear_inputs();
        es_valid = 1;
        ls_type = T_W;
        vaddr = {$urandom} & 32'hFFFF_FFFC;
        mem_re = (kind == 1);
        mem_we = (kind == 2);
        es_ex_in = (kind == 1);
        kill = (kind == 2);
        addr_ok = 1'($urandom);
        @(negedge clk);
        check("pass_req", data_sram_req, 0);
        check("pass_rdy_iss", {mem_ready_go, es_req_issued}, 2'b10);
    endtask

    task automatic run_flush();
        step();
        clear_inputs();
        es_valid = 1; mem_re = 1; ls_type = T_W; vaddr = 32'h2000_0010;
        sb.push_back(model(0, T_W, 32'h2000_0010, rt_value));
        expected_accepts++;
        @(negedge clk);
        check("fl_req0", data_sram_req, 1);
        step();
        flush = 1;
        @(negedge clk);
        check("fl_req1", {data_sram_req, mem_ready_go, es_req_issued}, 3'b100);
        step();
        flush = 0; es_valid = 0; mem_re = 0; vaddr = $urandom; ls_type = T_B;
        @(negedge clk);
        check("drain_hold", {data_sram_req, mem_ready_go, es_req_issued}, 3'b100);
        step();
        addr_ok = 1;
        @(negedge clk);
        check("drain_accept", {data_sram_req, mem_ready_go, es_req_issued}, 3'b100);
        step();
        addr_ok = 0;
        @(negedge clk);
        check("drain_to_idle", data_sram_req, 0);
    endtask

    task automatic run_reset_mid_req();
        step();
        clear_inputs();
        es_valid = 1; mem_we = 1; ls_type = T_W; vaddr = 32'h4000_0008;
        sb.push_back(model(1, T_W, 32'h4000_0008, rt_value));
        @(negedge clk);
        check("rst_req0", data_sram_req, 1);
        step();
        @(negedge clk);
        check("rst_req1", data_sram_req, 1);
        step();
        reset = 1; es_valid = 0; mem_we = 0;
        step();
        reset = 0;
        @(negedge clk);
        check("rst_after", {data_sram_req, mem_ready_go, es_req_issued}, 3'b000);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [2:0] st_types [5] = '{T_B, T_H, T_W, T_WL, T_WR};
        clear_inputs();
        reset = 1;
        step();
        step();
        @(negedge clk);
        check("reset_req", {data_sram_req, mem_ready_go, es_req_issued}, 3'b000);
        step();
        reset = 0;
        bubble();

        run_mem(1, T_W, 32'h1000_0004, $urandom, 0, 0);
        bubble();
        run_mem(1, T_B, 32'h1000_0102, 32'h1234_56AB, 3, 0);
        run_mem(0, T_W, 32'h1000_0202, $urandom, 0, 0);
        run_mem(1, T_H, 32'h1000_0301, $urandom, 0, 0);
        run_mem(1, T_WL, 32'h3000_0001, 32'hAABB_CCDD, 1, 1);
        run_mem(1, T_WR, 32'h3000_0003, 32'hAABB_CCDD, 2, 0);
        bubble();
        run_flush();
        bubble();
        run_pass(2);
        run_pass(1);
        run_pass(0);
        run_reset_mid_req();
        bubble();

        for (int n = 0; n < 300; n++) begin
            int unsigned r = $urandom_range(0, 9);
            if (r == 0) run_pass($urandom_range(0, 2));
            else if (r == 1) bubble();
            else begin
                bit st = 1'($urandom);
                bit [2:0] t = st ? st_types[$urandom_range(0, 4)] : 3'($urandom_range(0, 6));
                bit [31:0] va = $urandom;
                if ($urandom_range(0, 1) == 1) va[1:0] = 2'b00;
                run_mem(st, t, va, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
            end
        end
        bubble();

        check("sb_empty", sb.size(), 0);
        check("accept_count", accepted, expected_accepts);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
